// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: requests one word per PC from instruction memory,
// then releases the core for exactly one cycle with the fetched instruction.
module inst_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        core_clk_en,
  output logic [31:0] inst_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        fetch_err,
  output logic [31:0] retired_cnt,
  output logic [15:0] stall_cnt
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_ISSUE,
    ST_HALT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  // Only the word address is ever presented, so the byte offset is not kept.
  logic [31:2] r_addr_q;
  logic [31:0] r_inst_q;
  logic        r_fetch_err;
  logic [31:0] r_retired_cnt;
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_LOAD;
      r_addr_q      <= '0;
      r_inst_q      <= NOP_INST;
      r_fetch_err   <= 1'b0;
      r_retired_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_LOAD: begin
          r_addr_q <= pc_in[31:2];
          if (pc_in[1:0] != 2'b00) begin
            r_fetch_err <= 1'b1;
            r_inst_q    <= NOP_INST;
          end
        end
        ST_REQ: begin
          if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
        ST_WAIT: begin
          if (r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
          if (mem_rvalid) r_inst_q <= mem_rdata;
        end
        ST_ISSUE: r_retired_cnt <= r_retired_cnt + 32'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next      = r_state;
    core_clk_en = 1'b0;
    mem_req     = 1'b0;
    case (r_state)
      ST_LOAD:  w_next = (pc_in[1:0] == 2'b00) ? ST_REQ : ST_HALT;
      ST_REQ: begin
        mem_req = 1'b1;
        if (mem_gnt) w_next = ST_WAIT;
      end
      ST_WAIT:  if (mem_rvalid) w_next = ST_ISSUE;
      ST_ISSUE: begin
        core_clk_en = 1'b1;
        w_next      = ST_LOAD;
      end
      ST_HALT:  w_next = ST_HALT;
      default:  w_next = ST_LOAD;
    endcase
  end

  assign mem_addr    = {r_addr_q, 2'b00};
  assign inst_out    = r_inst_q;
  assign fetch_err   = r_fetch_err;
  assign retired_cnt = r_retired_cnt;
  assign stall_cnt   = r_stall_cnt;

endmodule
